// File: rtl/mini_src_control_unit.sv
// Hardwired Moore control sequencer for the Mini SRC datapath.
// Steps fetch/decode/execute T-states and decodes state + opcode into control strobes.
module mini_src_control_unit #(
  parameter int unsigned MEM_WAIT        = 0,
  parameter bit          HALT_ON_ILLEGAL = 1'b0
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        Stop,
  output logic        PCout, Zlowout, Zhighout, MDRout, LOout, HIout,
  output logic        PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin, CONin,
  output logic        AND, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, OR, NEG, NOT, IncPC,
  output logic        Read, Write,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout,
  output logic        Run,
  output logic        Illegal
);

  localparam logic [3:0] S_RST     = 4'd0;
  localparam logic [3:0] S_FETCH0  = 4'd1;
  localparam logic [3:0] S_FETCH1  = 4'd2;
  localparam logic [3:0] S_FETCH1W = 4'd3;
  localparam logic [3:0] S_FETCH2  = 4'd4;
  localparam logic [3:0] S_T3      = 4'd5;
  localparam logic [3:0] S_T4      = 4'd6;
  localparam logic [3:0] S_T5      = 4'd7;
  localparam logic [3:0] S_T6      = 4'd8;
  localparam logic [3:0] S_T6W     = 4'd9;
  localparam logic [3:0] S_T7      = 4'd10;
  localparam logic [3:0] S_HALT    = 4'd11;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Counter reload for N hold cycles counts N-1 down to 0.
  localparam bit         HAS_WAIT  = (MEM_WAIT != 0);
  localparam logic [3:0] WAIT_LOAD = 4'(HAS_WAIT ? MEM_WAIT - 1 : 0);

  logic [3:0] state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic [4:0] op;
  logic       is_ralu, is_ialu, is_ld, is_ldi, is_st, is_muldiv, is_negnot;
  logic       is_br, is_jr, is_mfhi, is_mflo, is_nop, is_halt, is_illegal;
  logic       last_t3, alu_en;
  logic [3:0] fetch_next;
  logic       unused_ir;

  assign op         = ir[31:27];
  assign unused_ir  = ^ir[26:0];
  assign is_ralu    = op inside {[OP_ADD:OP_SHL]};
  assign is_ialu    = op inside {[OP_ADDI:OP_ORI]};
  assign is_ld      = (op == OP_LD);
  assign is_ldi     = (op == OP_LDI);
  assign is_st      = (op == OP_ST);
  assign is_muldiv  = (op == OP_MUL) || (op == OP_DIV);
  assign is_negnot  = (op == OP_NEG) || (op == OP_NOT);
  assign is_br      = (op == OP_BR);
  assign is_jr      = (op == OP_JR);
  assign is_mfhi    = (op == OP_MFHI);
  assign is_mflo    = (op == OP_MFLO);
  assign is_nop     = (op == OP_NOP);
  assign is_halt    = (op == OP_HALT);
  assign is_illegal = !(is_ralu || is_ialu || is_ld || is_ldi || is_st || is_muldiv ||
                        is_negnot || is_br || is_jr || is_mfhi || is_mflo || is_nop || is_halt);
  assign last_t3    = is_jr || is_mfhi || is_mflo || is_nop || is_illegal;
  // Stop is honoured only at instruction boundaries, never straight out of RST.
  assign fetch_next = Stop ? S_HALT : S_FETCH0;

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q <= S_RST;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_RST:    state_d = S_FETCH0;
      S_FETCH0: state_d = S_FETCH1;
      S_FETCH1: begin
        if (HAS_WAIT) begin
          state_d = S_FETCH1W;
          wait_d  = WAIT_LOAD;
        end else begin
          state_d = S_FETCH2;
        end
      end
      S_FETCH1W: begin
        if (wait_q == 4'd0) state_d = S_FETCH2;
        else                wait_d  = wait_q - 4'd1;
      end
      S_FETCH2: state_d = S_T3;
      S_T3: begin
        if (is_halt || (is_illegal && HALT_ON_ILLEGAL)) state_d = S_HALT;
        else if (last_t3)                               state_d = fetch_next;
        else                                            state_d = S_T4;
      end
      S_T4: state_d = is_negnot ? fetch_next : S_T5;
      S_T5: state_d = (is_ralu || is_ialu || is_ldi) ? fetch_next : S_T6;
      S_T6: begin
        if (!is_ld) begin
          state_d = fetch_next;
        end else if (HAS_WAIT) begin
          state_d = S_T6W;
          wait_d  = WAIT_LOAD;
        end else begin
          state_d = S_T7;
        end
      end
      S_T6W: begin
        if (wait_q == 4'd0) state_d = S_T7;
        else                wait_d  = wait_q - 4'd1;
      end
      S_T7:    state_d = fetch_next;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  always_comb begin
    {PCout, Zlowout, Zhighout, MDRout, LOout, HIout} = '0;
    {PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin, CONin} = '0;
    {AND, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, OR, NEG, NOT, IncPC} = '0;
    {Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, Illegal} = '0;
    alu_en = 1'b0;
    Run    = (state_q != S_RST) && (state_q != S_HALT);
    case (state_q)
      S_FETCH0:  begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_FETCH1:  begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_FETCH1W: begin Read = 1'b1; MDRin = 1'b1; end
      S_FETCH2:  begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (is_ralu || is_ialu)            begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        if (is_ld || is_ldi || is_st)      begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
        if (is_muldiv)                     begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        if (is_negnot)                     begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_en = 1'b1; end
        if (is_br)                         begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
        if (is_jr)                         begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
        if (is_mfhi)                       begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        if (is_mflo)                       begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        Illegal = is_illegal;
      end
      S_T4: begin
        if (is_ralu)                       begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_en = 1'b1; end
        if (is_ialu)                       begin Cout = 1'b1; Zin = 1'b1; alu_en = 1'b1; end
        if (is_ld || is_ldi || is_st)      begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
        if (is_muldiv)                     begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_en = 1'b1; end
        if (is_negnot)                     begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        if (is_br)                         begin PCout = 1'b1; Yin = 1'b1; end
      end
      S_T5: begin
        if (is_ralu || is_ialu || is_ldi)  begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        if (is_ld || is_st)                begin Zlowout = 1'b1; MARin = 1'b1; end
        if (is_muldiv)                     begin Zlowout = 1'b1; LOin = 1'b1; end
        if (is_br)                         begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
      end
      S_T6: begin
        if (is_ld)                         begin Read = 1'b1; MDRin = 1'b1; end
        if (is_st)                         begin Gra = 1'b1; Rout = 1'b1; Write = 1'b1; end
        if (is_muldiv)                     begin Zhighout = 1'b1; HIin = 1'b1; end
        if (is_br && con_ff)               begin Zlowout = 1'b1; PCin = 1'b1; end
      end
      S_T6W: begin Read = 1'b1; MDRin = 1'b1; end
      S_T7:  begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      default: ;
    endcase
    if (alu_en) begin
      case (op)
        OP_ADD, OP_ADDI: ADD  = 1'b1;
        OP_SUB:          SUB  = 1'b1;
        OP_AND, OP_ANDI: AND  = 1'b1;
        OP_OR, OP_ORI:   OR   = 1'b1;
        OP_ROR:          ROR  = 1'b1;
        OP_ROL:          ROL  = 1'b1;
        OP_SHR:          SHR  = 1'b1;
        OP_SHRA:         SHRA = 1'b1;
        OP_SHL:          SHL  = 1'b1;
        OP_MUL:          MUL  = 1'b1;
        OP_DIV:          DIV  = 1'b1;
        OP_NEG:          NEG  = 1'b1;
        OP_NOT:          NOT  = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mini_src_control_unit.md
Name: mini_src_control_unit

Overview:
- Hardwired Moore control sequencer for the Mini SRC processor. It sits directly upstream of the datapath.
- Reads the IR contents and the branch-condition flag, and steps through fetch/decode/execute T-states.
- Drives every one-bit control strobe the datapath consumes: bus out-selects, register in-enables, ALU op strobes, memory Read/Write, and Gra/Grb/Grc/Rin/Rout/BAout for the select-encode block.

Parameters:
- MEM_WAIT, 0: extra cycles Read/MDRin are held in memory-read states (0..15).
- HALT_ON_ILLEGAL, 0: 0 = illegal opcode returns to FETCH0; 1 = enters HALT.

Ports:
- Clock  in  1  system clock, rising edge.
- Clear  in  1  synchronous active-high reset.
- ir  in  32  IR register contents; opcode = ir[31:27].
- con_ff  in  1  branch-condition flag from CON FF logic.
- Stop  in  1  request halt at next instruction boundary.
- PCout Zlowout Zhighout MDRout LOout HIout  out  1 each  bus source selects.
- PCin IRin MARin MDRin Yin Zin LOin HIin CONin  out  1 each  register enables.
- AND ADD SUB MUL DIV SHR SHRA SHL ROR ROL OR NEG NOT IncPC  out  1 each  ALU op strobes.
- Read Write  out  1 each  memory strobes.
- Gra Grb Grc Rin Rout BAout Cout  out  1 each  select-encode / immediate controls.
- Run  out  1  high while executing.
- Illegal  out  1  one-cycle pulse on unsupported opcode.

Behaviour:
- Clocking and reset: one clock. Clear is synchronous active-high and is sampled on the rising Clock edge. Clear forces state RST and wait counter to 0, overriding all other inputs including mid-instruction.
- Output encoding: Moore. Outputs are a pure decode of the state register plus ir/con_ff where noted. In RST and HALT every output is 0, including Run. Run=1 in all other states.
- RST -> FETCH0 unconditionally on the first cycle after Clear is low.
- FETCH0: PCout MARin IncPC Zin. If Stop=1 on entry, go to HALT instead and assert nothing.
- FETCH1: Zlowout PCin Read MDRin.
- FETCH1W: Read MDRin only, held for MEM_WAIT cycles by a 4-bit down-counter. Skipped when MEM_WAIT=0.
- FETCH2: MDRout IRin.
- T3+ follow by opcode (ra=ir[26:23], rb=ir[22:19], rc=ir[18:15], C=ir[18:0]):
  - R-ALU (add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011): T3 Grb Rout Yin; T4 Grc Rout op Zin; T5 Zlowout Gra Rin.
  - I-ALU (addi 01100, andi 01101, ori 01110): T3 Grb Rout Yin; T4 Cout op(ADD/AND/OR) Zin; T5 Zlowout Gra Rin.
  - ld 00000: T3 Grb BAout Yin; T4 Cout ADD Zin; T5 Zlowout MARin; T6 Read MDRin (+MEM_WAIT hold cycles); T7 MDRout Gra Rin.
  - ldi 00001: T3-T4 as ld; T5 Zlowout Gra Rin.
  - st 00010: T3-T5 as ld; T6 Gra Rout Write.
  - mul 10000 / div 01111: T3 Gra Rout Yin; T4 Grb Rout MUL|DIV Zin; T5 Zlowout LOin; T6 Zhighout HIin.
  - neg 10001 / not 10010: T3 Grb Rout op Zin; T4 Zlowout Gra Rin.
  - br 10011: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout ADD Zin; T6 Zlowout PCin only if con_ff=1, else no strobes.
  - jr 10100: T3 Gra Rout PCin.
  - mfhi 11000: T3 HIout Gra Rin. mflo 11001: T3 LOout Gra Rin.
  - nop 11010: T3 no strobes.
  - halt 11011: T3 -> HALT.
  - All others (jal, in, out, 11100-11111): T3 asserts Illegal, then FETCH0 or HALT per HALT_ON_ILLEGAL.
- After the last T-state of an instruction, the next state is FETCH0.
- ir is sampled combinationally in T3 onward. IR is stable because IRin is only asserted in FETCH2.
- HALT is absorbing; only Clear exits it.
- At most one bus-source select is high in any state. Read and Write are never high together.

Test Plan:
- Clear high 3 cycles mid-ld, then low -> one RST cycle with all outputs 0, then FETCH0 with PCout=MARin=IncPC=Zin=1 and Run=1.
- ir=0x1A920000 (add R5,R2,R4), MEM_WAIT=0 -> 6 cycles FETCH0..T5. T4 has Grc Rout ADD Zin; T5 has Zlowout Gra Rin; then FETCH0.
- ir=0x00900054 (ld R1,0x54(R2)) with MEM_WAIT=2 -> FETCH1 plus 2 hold cycles with Read=1 and PCin only in the first. T6 Read held 3 cycles; T7 MDRout Gra Rin; 12 cycles total.
- ir=0x9A80000E (br R5,14): con_ff=1 at T6 -> Zlowout=PCin=1; repeat with con_ff=0 -> all strobes 0 at T6, then FETCH0.
- ir=0x80000000 (mul): T5 Zlowout LOin, T6 Zhighout HIin. ir=0xD8000000 (halt) -> HALT, Run=0, outputs 0 for 20 cycles; Clear recovers to FETCH0.
- ir=0xA8000000 (jal) with HALT_ON_ILLEGAL=0 -> Illegal=1 for exactly one cycle, then FETCH0. Stop=1 entering FETCH0 -> HALT with no fetch strobes.
